dsp_loader: RTL
===============

Name: dsp_loader

Overview:
- Upstream feeder for the dsp stage.
- Accepts a byte stream over a valid/ready handshake and packs the bytes MSB-first into bus_width-bit words.
- Presents each completed word to the dsp input with a one-cycle write strobe.
- After a frame of words has been written, issues a one-cycle start pulse so the dsp stage can begin processing.

Parameters:
- bus_width, 24, packed word width in bits; must be a multiple of 8 and at least 8.
- frame_words, 2, number of words per frame; range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  loader enable; when low, no bytes are accepted.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_last  in  1  marks the last byte of a frame; only meaningful while s_valid is high.
- s_ready  out  1  loader can accept a byte this cycle.
- din  out  bus_width  packed word to the dsp stage.
- we  out  1  one-cycle write strobe for din.
- start  out  1  one-cycle frame-complete pulse.
- busy  out  1  high while a frame is partially loaded.
- frame_len  out  8  number of words in the last completed frame.

Behaviour:
- BPW = bus_width/8 bytes per word.
- Internal state: acc (bus_width bits), byte_idx (0..BPW-1), word_cnt (0..frame_words-1), last_seen flag.
- A byte is accepted when s_valid and s_ready are both high in the same cycle.
- State machine, three states: LOAD, EMIT, DONE. Reset enters LOAD.
- LOAD:
  - s_ready = en (combinational).
  - An accepted byte k is written to acc[bus_width-1-8k -: 8]. acc is zero at each word start, so missing bytes read as 0.
  - The word completes when byte_idx == BPW-1 or s_last is set on the accepted byte. Completion moves to EMIT and latches last_seen = s_last. Otherwise byte_idx increments.
  - en low: hold acc, byte_idx and word_cnt unchanged; the partial word is kept.
- EMIT (exactly one cycle):
  - s_ready = 0; registered outputs hold din = acc and we = 1.
  - Clear acc and byte_idx.
  - If last_seen or word_cnt == frame_words-1: go to DONE.
  - Else: word_cnt++ and go to LOAD.
- DONE (exactly one cycle):
  - s_ready = 0, start = 1, frame_len = word_cnt+1.
  - Clear word_cnt and last_seen; go to LOAD.
- Latency:
  - Final byte of a word accepted at cycle N → we high during cycle N+1.
  - Final word of a frame → start high during cycle N+2.
  - The next byte can be accepted at N+2 for a mid-frame word, or N+3 after a frame.
  - Sustained throughput is BPW bytes per BPW+1 cycles.
- din holds its value after we falls, until the next EMIT.
- s_last on the first byte of a word gives a zero-padded word, e.g. 0xAA0000 for bus_width=24.
- s_last on the word that is also number frame_words: a single frame ends normally, with no extra start.
- Frame shorter than frame_words (s_last early): start still pulses; frame_len reports the short length.
- busy = 1 when byte_idx != 0, or word_cnt != 0, or state != LOAD. busy = 0 in DONE only after it completes, i.e. in the following LOAD cycle with counters cleared.
- s_data and s_last are ignored when s_valid is low or s_ready is low.
- Reset values: din = 0, we = 0, start = 0, busy = 0, frame_len = 0, s_ready = 0 while rst is high. acc, byte_idx, word_cnt and last_seen are cleared.
- Reset mid-frame: the partial word and count are discarded; no we or start is produced for the aborted frame.
- rst has priority over all other inputs in the same cycle.

Test Plan:
- Continuous bytes:
  - Stimulus: bus_width=24, frame_words=2, en=1, s_valid held high; bytes 11 22 33 44 55 66, s_last on 66.
  - Response: we in the cycle after 33 with din=0x112233; we in the cycle after 66 with din=0x445566; start the next cycle with frame_len=2; s_ready low during the EMIT and DONE cycles.
- Short frame:
  - Stimulus: byte AA with s_last=1.
  - Response: we with din=0xAA0000, then start with frame_len=1; busy returns to 0.
- Backpressure and gaps:
  - Stimulus: bytes 01 02 with en dropped for 5 cycles between them, then 03; separately, s_valid dropped 3 cycles mid-word.
  - Response: din=0x010203, one we only; no bytes accepted while en=0.
- Reset mid-word:
  - Stimulus: bytes 7A 7B, rst high 1 cycle, then C1 C2 C3 with s_last.
  - Response: no we or start for 7A 7B; one we with din=0xC1C2C3, then start with frame_len=1.
- Full frame without s_last:
  - Stimulus: frame_words=2; 6 bytes, none marked s_last.
  - Response: start after the second word; the 7th byte begins a new frame with word_cnt=0.
- Parameter variant:
  - Stimulus: bus_width=8, frame_words=3; bytes 5A 5B 5C.
  - Response: three we pulses, each one cycle after its byte; start after the third with frame_len=3.

Source files
------------

// File: rtl/dsp_loader.sv
// dsp_loader: packs an MSB-first byte stream into bus_width-bit words for the dsp stage.
// Each finished word is presented with a one-cycle write strobe. After the last word of a
// frame, a one-cycle start pulse follows. A frame ends early when s_last is seen.
module dsp_loader #(
   parameter int unsigned bus_width   = 24,
   parameter int unsigned frame_words = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 s_valid,
   input  logic [7:0]           s_data,
   input  logic                 s_last,
   output logic                 s_ready,
   output logic [bus_width-1:0] din,
   output logic                 we,
   output logic                 start,
   output logic                 busy,
   output logic [7:0]           frame_len
);

   localparam int unsigned Bpw  = bus_width / 8;
   localparam int unsigned IdxW = (Bpw > 1) ? $clog2(Bpw) : 1;

   typedef enum logic [1:0] {
      StLoad,
      StEmit,
      StDone
   } state_e;

   state_e               state_q, state_d;
   logic [bus_width-1:0] acc_q, acc_d;
   logic [bus_width-1:0] acc_ins;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 last_q, last_d;
   logic [bus_width-1:0] din_q, din_d;
   logic                 we_q, we_d;
   logic                 start_q, start_d;
   logic [7:0]           len_q, len_d;
   logic                 accept;
   logic                 word_done;

   // Handshake and status. Both are forced low while reset is held.
   always_comb begin
      s_ready   = !rst && en && (state_q == StLoad);
      accept    = s_valid && s_ready;
      word_done = accept && ((idx_q == IdxW'(Bpw - 1)) || s_last);
      busy      = !rst && ((idx_q != '0) || (cnt_q != '0) || (state_q != StLoad));
   end

   // Insert the incoming byte into the accumulator slot selected by the byte index.
   always_comb begin
      acc_ins = acc_q;
      for (int unsigned b = 0; b < Bpw; b++) begin
         if (idx_q == IdxW'(b)) begin
            acc_ins[bus_width-1-8*b -: 8] = s_data;
         end
      end
   end

   // Next-state logic for the three-state LOAD/EMIT/DONE machine.
   // din/we/start/frame_len are computed one cycle early so that they come out registered.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      din_d   = din_q;
      we_d    = 1'b0;
      start_d = 1'b0;
      len_d   = len_q;
      unique case (state_q)
         StLoad: begin
            if (accept) begin
               acc_d = acc_ins;
               if (word_done) begin
                  state_d = StEmit;
                  last_d  = s_last;
                  din_d   = acc_ins;
                  we_d    = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StEmit: begin
            // Start the next word from zero so that missing bytes read as 0.
            acc_d = '0;
            idx_d = '0;
            if (last_q || (cnt_q == 8'(frame_words - 1))) begin
               state_d = StDone;
               start_d = 1'b1;
               len_d   = cnt_q + 8'd1;
            end else begin
               cnt_d   = cnt_q + 8'd1;
               state_d = StLoad;
            end
         end
         StDone: begin
            cnt_d   = '0;
            last_d  = 1'b0;
            state_d = StLoad;
         end
         default: begin
            state_d = StLoad;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StLoad;
         acc_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         din_q   <= '0;
         we_q    <= 1'b0;
         start_q <= 1'b0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         din_q   <= din_d;
         we_q    <= we_d;
         start_q <= start_d;
         len_q   <= len_d;
      end
   end

   assign din       = din_q;
   assign we        = we_q;
   assign start     = start_q;
   assign frame_len = len_q;

endmodule
